dadda_mac_accum: RTL and testbench
==================================

# dadda_mac_accum

Sequential accumulation stage that sits directly downstream of the 8x8 Dadda multiplier with ripple-carry final adder. It accepts the multiplier's 16-bit unsigned products under a valid/ready handshake, sums a fixed number of them into a wide accumulator, and presents the dot-product result with its own valid/ready handshake. The block adds pipelining and flow control around the purely combinational multiplier, making it usable as a MAC datapath.

## Interface
- ACC_W, 24: accumulator and result width in bits; legal range 16..32.
- N_TERMS, 8: products per dot product; legal range 1..255.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort: discards the partial sum and returns to IDLE.
- in_valid  input  1  the `product` input carries a term.
- in_ready  output  1  the block can accept a term.
- product  input  16  unsigned product from the multiplier.
- out_valid  output  1  the `acc_out` output holds a finished result.
- out_ready  input  1  downstream consumes the result.
- acc_out  output  ACC_W  registered accumulated sum.
- ovf  output  1  overflow flag for the current or held result.

## Operation
- States: IDLE, ACCUM, DONE. Term counter `cnt` is 8 bits wide.
- A transfer ("accept") occurs when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, and 0 in DONE.
- IDLE + accept:
  - acc <= zero-extended product; ovf <= 0; cnt <= 1.
  - Next state is DONE if N_TERMS == 1, otherwise ACCUM.
- ACCUM + accept:
  - acc <= acc + product, computed ACC_W+1 bits wide; cnt <= cnt + 1.
  - When the accepted term is the N_TERMS-th, the next state is DONE.
- ACCUM without accept: everything holds. Bubbles are legal and unlimited.
- DONE:
  - out_valid = 1; acc_out and ovf are held stable.
  - When out_valid && out_ready, the next state is IDLE and cnt <= 0. acc_out keeps its last value until the next IDLE accept.
- Arithmetic: unsigned. Overflow means the carry out of bit ACC_W-1 is set. ovf is sticky for the duration of the dot product.
- clear has priority over every other event:
  - Next state is IDLE; acc <= 0; cnt <= 0; ovf <= 0.
  - A term presented in the same cycle is not accepted; in_ready is still 1, but the bench ignores that transfer.
  - A pending DONE result is dropped.

## Timing
- Reset values: state IDLE, acc_out 0, ovf 0, out_valid 0, in_ready 1, cnt 0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency: out_valid rises in the cycle after the clock edge that accepts the last term.
- Throughput: one term per cycle. Back-to-back dot products cost one extra cycle, the IDLE accept slot following the DONE handshake.
- out_valid stays high, and in_ready stays low, until out_ready is sampled high.
- Asserting rst_n low mid-operation forces the reset values immediately, independent of clk.

## Configuration
- ACC_SAT_EN defined:
  - On overflow, acc saturates to all-ones (2^ACC_W − 1) and ovf <= 1.
  - Later additions keep the saturated value.
- ACC_SAT_EN undefined:
  - On overflow, acc wraps modulo 2^ACC_W and ovf <= 1.
  - Later additions continue from the wrapped value.

## Test plan
- Nominal sum, defaults: feed 8 products of 65025 (255×255) back-to-back.
  - out_valid rises 1 cycle after the 8th accept.
  - acc_out = 520200 (0x07F008); ovf = 0.
- Bubbles and backpressure, defaults:
  - Feed products 1..8 with in_valid low on alternate cycles, and hold out_ready low for 5 cycles.
  - acc_out = 36 and is stable; out_valid stays high; in_ready = 0 throughout.
  - IDLE follows the first cycle with out_ready = 1.
- Overflow, ACC_W = 16, N_TERMS = 2: feed 65025 twice.
  - ACC_SAT_EN undefined: acc_out = 0xFC02, ovf = 1.
  - ACC_SAT_EN defined: acc_out = 0xFFFF, ovf = 1.
- ovf reset on the next run: after the overflow case, feed 2 products of 3.
  - acc_out = 6 and ovf = 0.
- clear mid-run, defaults:
  - Accept 3 terms, then assert clear together with in_valid for one cycle, then feed 8 terms of 2.
  - acc_out = 16; the term offered during clear is not counted.
- Asynchronous reset: drop rst_n between clock edges during ACCUM, then release it.
  - Outputs go to their reset values immediately, with no clock edge.
  - After release, a fresh run of 8 × 10 gives acc_out = 80.

Source files
------------

// File: rtl/dadda_mac_accum_if.sv
// Handshake bundle between the Dadda multiplier, the accumulation stage and its consumer.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface dadda_mac_accum_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, acc_out, ovf
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, acc_out, ovf
    );
endinterface

// File: rtl/dadda_mac_accum.sv
// Accumulates N_TERMS 16-bit unsigned products into an ACC_W-bit dot-product result.
// Define ACC_SAT_EN to saturate on overflow; otherwise the accumulator wraps.
module dadda_mac_accum #(
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    dadda_mac_accum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);
    localparam bit         SINGLE   = (N_TERMS == 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf_r;
    logic             accept;
    logic             last;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_add;

    // clear blocks the transfer even though in_ready still reads 1
    assign accept = bus.in_valid && (state != DONE) && !clear;
    assign last   = (cnt == LAST_CNT);
    assign sum    = {1'b0, acc} + (ACC_W+1)'(bus.product);
    assign carry  = sum[ACC_W];

`ifdef ACC_SAT_EN
    assign acc_add = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = SINGLE ? DONE : ACCUM;
                ACCUM:   if (accept && last) state_nxt = DONE;
                DONE:    if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state != DONE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc   <= ACC_W'(bus.product);
                        ovf_r <= 1'b0;
                        cnt   <= 8'd1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc_add;
                        ovf_r <= ovf_r | carry;
                        cnt   <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) cnt <= '0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign bus.acc_out = acc;
    assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_dadda_mac_accum.sv
// Directed bench for dadda_mac_accum: a default instance (24-bit, 8 terms) and a
// narrow instance (16-bit, 2 terms) for the overflow cases; honours ACC_SAT_EN.
module tb_dadda_mac_accum;
    logic clk;
    logic rst_n;
    logic clear0;
    logic clear1;
    int   errors;
    int   checks;

    dadda_mac_accum_if #(.ACC_W(24)) if0 ();
    dadda_mac_accum_if #(.ACC_W(16)) if1 ();

    dadda_mac_accum #(.ACC_W(24), .N_TERMS(8)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear0),
        .bus   (if0)
    );

    dadda_mac_accum #(.ACC_W(16), .N_TERMS(2)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear1),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear0 = 1'b0;
        clear1 = 1'b0;
        if0.in_valid = 1'b0; if0.product = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.product = '0; if1.out_ready = 1'b0;

        #12;
        check("rst_in_ready",  if0.in_ready,  1);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_acc_out",   if0.acc_out,   0);
        check("rst_ovf",       if0.ovf,       0);
        rst_n = 1'b1;
        tick();

        // nominal: 8 x 65025 back to back
        for (int i = 0; i < 8; i++) begin
            if0.in_valid = 1'b1;
            if0.product  = 16'd65025;
            tick();
            if (i == 6) check("nom_valid_before_last", if0.out_valid, 0);
        end
        if0.in_valid = 1'b0;
        check("nom_out_valid", if0.out_valid, 1);
        check("nom_in_ready",  if0.in_ready,  0);
        check("nom_acc_out",   if0.acc_out,   32'd520200);
        check("nom_ovf",       if0.ovf,       0);
        if0.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;
        check("nom_hs_out_valid", if0.out_valid, 0);
        check("nom_hs_in_ready",  if0.in_ready,  1);
        check("nom_hs_acc_hold",  if0.acc_out,   32'd520200);

        // bubbles and backpressure: 1..8 on alternate cycles
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) begin
                if0.in_valid = 1'b0;
                tick();
            end
            if0.in_valid = 1'b1;
            if0.product  = 16'(i);
            tick();
        end
        if0.product = 16'd1000;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", if0.out_valid, 1);
            check("bp_in_ready",  if0.in_ready,  0);
            check("bp_acc_out",   if0.acc_out,   36);
            tick();
        end
        if0.in_valid = 1'b0;
        check("bp_acc_after_hold", if0.acc_out, 36);
        if0.out_ready = 1'b1;
        tick();
        if0.out_ready = 1'b0;
        check("bp_idle_out_valid", if0.out_valid, 0);
        check("bp_idle_in_ready",  if0.in_ready,  1);

        // overflow on the narrow instance
        if1.in_valid = 1'b1;
        if1.product  = 16'd65025;
        tick();
        check("ov_ovf_first", if1.ovf, 0);
        tick();
        if1.in_valid = 1'b0;
        check("ov_out_valid", if1.out_valid, 1);
`ifdef ACC_SAT_EN
        check("ov_acc_out", if1.acc_out, 32'hFFFF);
`else
        check("ov_acc_out", if1.acc_out, 32'hFC02);
`endif
        check("ov_ovf", if1.ovf, 1);
        if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;

        // next run clears ovf
        if1.in_valid = 1'b1;
        if1.product  = 16'd3;
        tick();
        tick();
        if1.in_valid = 1'b0;
        check("ov2_out_valid", if1.out_valid, 1);
        check("ov2_acc_out",   if1.acc_out,   6);
        check("ov2_ovf",       if1.ovf,       0);
        if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;

        // clear mid-run: 3 terms, clear with a term offered, then 8 x 2
        if0.in_valid = 1'b1;
        if0.product  = 16'd5;
        tick(); tick(); tick();
        check("clr_partial", if0.acc_out, 15);
        clear0 = 1'b1;
        if0.product = 16'd100;
        tick();
        clear0 = 1'b0;
        check("clr_acc_zero",  if0.acc_out,   0);
        check("clr_out_valid", if0.out_valid, 0);
        check("clr_in_ready",  if0.in_ready,  1);
        if0.product = 16'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) check("clr_valid_before_last", if0.out_valid, 0);
        end
        if0.in_valid = 1'b0;
        check("clr_out_valid_done", if0.out_valid, 1);
        check("clr_acc_out",        if0.acc_out,   16);
        clear0 = 1'b1;
        tick();
        clear0 = 1'b0;
        check("clr_drop_valid", if0.out_valid, 0);
        check("clr_drop_acc",   if0.acc_out,   0);

        // asynchronous reset during ACCUM
        if0.in_valid = 1'b1;
        if0.product  = 16'd10;
        tick(); tick(); tick();
        if0.in_valid = 1'b0;
        check("ar_partial", if0.acc_out, 30);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_acc_out",   if0.acc_out,   0);
        check("ar_out_valid", if0.out_valid, 0);
        check("ar_in_ready",  if0.in_ready,  1);
        check("ar_ovf",       if0.ovf,       0);
        #2;
        rst_n = 1'b1;
        if0.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        if0.in_valid = 1'b0;
        check("ar_run_valid", if0.out_valid, 1);
        check("ar_run_acc",   if0.acc_out,   80);
        check("ar_run_ovf",   if0.ovf,       0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
